// File: rtl/rom_read_arbiter_if.sv
// Reader-side bus of rom_read_arbiter: per-channel request/address in,
// one-hot grant, shared read data and one-hot read-valid out.
interface rom_read_arbiter_if #(
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 12,
  parameter int CHANNELS   = 2
);
  logic [CHANNELS-1:0]            req;
  logic [CHANNELS*ADDR_WIDTH-1:0] addr;
  logic [CHANNELS-1:0]            gnt;
  logic [DATA_WIDTH-1:0]          rdata;
  logic [CHANNELS-1:0]            rvalid;

  // Readers drive requests and addresses
  modport master (
    output req,
    output addr,
    input  gnt,
    input  rdata,
    input  rvalid
  );

  // Arbiter grants and returns data
  modport slave (
    input  req,
    input  addr,
    output gnt,
    output rdata,
    output rvalid
  );
endinterface

// File: rtl/rom_read_arbiter.sv
// Round-robin sharing of one synchronous block-ROM read port among CHANNELS
// readers. A one-hot tag pipeline matched to the ROM latency steers returned
// data to the issuing channel via rvalid.
module rom_read_arbiter #(
  parameter int ADDR_WIDTH  = 17,
  parameter int DATA_WIDTH  = 12,
  parameter int CHANNELS    = 2,
  parameter int ROM_LATENCY = 1,
  parameter int REG_OUTPUT  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  rom_read_arbiter_if.slave     rd,
  output logic                  rom_en,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_dout
);

  localparam int PW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  if (CHANNELS < 1 || CHANNELS > 8) begin : g_bad_channels
    $fatal(1, "rom_read_arbiter: CHANNELS must be 1..8");
  end
  if (ROM_LATENCY < 1 || ROM_LATENCY > 4) begin : g_bad_latency
    $fatal(1, "rom_read_arbiter: ROM_LATENCY must be 1..4");
  end

  logic [PW-1:0]         ptr_q;
  logic [PW-1:0]         ptr_nxt;
  logic [PW-1:0]         sel;
  logic [PW-1:0]         cand;
  logic                  found;
  logic [CHANNELS-1:0]   gnt_c;
  int unsigned           idx;
  int unsigned           nxt;
  logic [ADDR_WIDTH-1:0] addr_arr [CHANNELS];
  logic [CHANNELS-1:0]   tag_q    [ROM_LATENCY];
  logic [CHANNELS-1:0]   tag_last;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_addr
    assign addr_arr[g] = rd.addr[g*ADDR_WIDTH +: ADDR_WIDTH];
  end

  // Rotating search from ptr; first requesting channel wins, nothing during reset
  always_comb begin
    found = 1'b0;
    sel   = ptr_q;
    cand  = ptr_q;
    idx   = 0;
    nxt   = 0;
    gnt_c = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      cand = PW'(idx);
      if (!found && rd.req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
    if (found && !rst) gnt_c[sel] = 1'b1;
    nxt = 32'(sel) + 1;
    if (nxt >= CHANNELS) nxt = 0;
    ptr_nxt = PW'(nxt);
  end

  assign rd.gnt   = gnt_c;
  assign rom_en   = |gnt_c;
  assign rom_addr = addr_arr[sel];

  // Priority pointer moves just past the channel granted this cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (|gnt_c) begin
      ptr_q <= ptr_nxt;
    end
  end

  // Grant tags ride alongside the ROM read so the last stage lines up with rom_dout
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned s = 0; s < ROM_LATENCY; s++) tag_q[s] <= '0;
    end else begin
      tag_q[0] <= gnt_c;
      for (int unsigned s = 1; s < ROM_LATENCY; s++) tag_q[s] <= tag_q[s-1];
    end
  end

  assign tag_last = tag_q[ROM_LATENCY-1];

  if (REG_OUTPUT != 0) begin : g_reg_out
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [CHANNELS-1:0]   rvalid_q;

    // Capture ROM word only when a tag exits; otherwise hold the last word
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rdata_q  <= '0;
        rvalid_q <= '0;
      end else begin
        rvalid_q <= tag_last;
        if (|tag_last) rdata_q <= rom_dout;
      end
    end

    assign rd.rdata  = rdata_q;
    assign rd.rvalid = rvalid_q;
  end else begin : g_comb_out
    assign rd.rdata  = rom_dout;
    assign rd.rvalid = tag_last;
  end

endmodule
